// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO between the fetch and decode stages.
// Each entry holds {instruction, programCounter, programCounterPlus4}, with a
// valid/ready handshake on both sides and a flush that drops every entry.
//
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty and
// fetch presents a payload, that payload is forwarded to decode in the same
// cycle. If decode takes it, it is never written into the storage array.
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally modulo DEPTH.
module fetch_queue #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enqValid,
  output logic             enqReady,
  input  logic [WIDTH-1:0] enqData,
  output logic             deqValid,
  input  logic             deqReady,
  output logic [WIDTH-1:0] deqData,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic full_w;
  logic empty_w;
  logic bypass_w;     // forwarding path is active this cycle
  logic pass_w;       // forwarded payload is consumed directly by decode
  logic enq_fire;     // handshake on the enqueue side
  logic deq_fire;     // handshake on the dequeue side, taken from storage
  logic enq_write;    // enqueue that actually changes state (flush wins)
  logic deq_pop;      // dequeue that actually changes state (flush wins)

  // Status flags come from registered occupancy only.
  always_comb begin
    full_w  = (count_q == DEPTH_C);
    empty_w = (count_q == '0);
  end

  // Forwarding path (only with the bypass build); otherwise outputs are
  // taken from registered state only.
`ifdef FETCH_QUEUE_BYPASS_EN
  always_comb begin
    bypass_w = empty_w && enqValid && !flush;
    pass_w   = bypass_w && deqReady;
  end
`else
  always_comb begin
    bypass_w = 1'b0;
    pass_w   = 1'b0;
  end
`endif

  // Handshake decode; enqReady never looks at deqReady, so there is no
  // ready loop through the queue.
  always_comb begin
    enqReady  = !full_w;
    deqValid  = !empty_w || bypass_w;
    deqData   = bypass_w ? enqData : mem_q[head_q];
    count     = count_q;
    full      = full_w;
    empty     = empty_w;
    enq_fire  = enqValid && !full_w;
    deq_fire  = !empty_w && deqReady;
    enq_write = enq_fire && !pass_w && !flush;
    deq_pop   = deq_fire && !flush;
  end

  // Next pointer and occupancy; flush overrides any handshake in its cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_write) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (deq_pop) begin
        head_d = head_q + PTR_ONE;
      end
      if (enq_write && !deq_pop) begin
        count_d = count_q + ONE_C;
      end else if (deq_pop && !enq_write) begin
        count_d = count_q - ONE_C;
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left unreset; contents are only
  // observable through a valid handshake.
  always_ff @(posedge clock) begin
    if (enq_write) begin
      mem_q[tail_q] <= enqData;
    end
  end

`ifndef SYNTHESIS
  // Occupancy must stay within the array.
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= DEPTH_C);

  // No payload may be written into a full queue.
  a_no_enq_full: assert property (@(posedge clock) disable iff (reset)
    !(enq_write && full_w));

  // No entry may be popped from an empty queue.
  a_no_deq_empty: assert property (@(posedge clock) disable iff (reset)
    !(deq_pop && empty_w));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int WIDTH = 96;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             enqValid;
  logic             enqReady;
  logic [WIDTH-1:0] enqData;
  logic             deqValid;
  logic             deqReady;
  logic [WIDTH-1:0] deqData;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mq[$];

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .enqValid (enqValid),
    .enqReady (enqReady),
    .enqData  (enqData),
    .deqValid (deqValid),
    .deqReady (deqReady),
    .deqData  (deqData),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [31:0] pc);
    logic [31:0] instr;
    instr = {pc[15:0], 16'h0013} ^ 32'h5a5a0000;
    return {instr, pc, pc + 32'd4};
  endfunction

  // One cycle: drive inputs after the falling edge, compare outputs against
  // the model, then advance the model as the coming rising edge will.
  task automatic step(input logic fl, input logic ev, input logic [WIDTH-1:0] d,
                      input logic dr, output logic took, output logic [31:0] pc_out);
    bit m_empty;
    bit m_full;
    bit byp;
    @(negedge clock);
    flush    = fl;
    enqValid = ev;
    enqData  = d;
    deqReady = dr;
    #1;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    byp     = BYP && m_empty && ev && !fl;
    chk("count",    WIDTH'(count),    WIDTH'(mq.size()));
    chk("empty",    WIDTH'(empty),    WIDTH'(m_empty));
    chk("full",     WIDTH'(full),     WIDTH'(m_full));
    chk("enqReady", WIDTH'(enqReady), WIDTH'(!m_full));
    chk("deqValid", WIDTH'(deqValid), WIDTH'(!m_empty || byp));
    if (byp) chk("deqData_bypass", deqData, d);
    else if (!m_empty) chk("deqData", deqData, mq[0]);
    took   = deqValid && deqReady;
    pc_out = deqData[63:32];
    if (fl) begin
      mq.delete();
    end else if (!(byp && dr)) begin
      if (!m_empty && dr) void'(mq.pop_front());
      if (ev && !m_full) mq.push_back(d);
    end
  endtask

  initial begin
    logic        took;
    logic [31:0] pc;
    int          k;

    reset = 1'b1; flush = 1'b0; enqValid = 1'b0; enqData = '0; deqReady = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_count",    WIDTH'(count),    WIDTH'(0));
    chk("rst_empty",    WIDTH'(empty),    WIDTH'(1));
    chk("rst_full",     WIDTH'(full),     WIDTH'(0));
    chk("rst_enqReady", WIDTH'(enqReady), WIDTH'(1));
    chk("rst_deqValid", WIDTH'(deqValid), WIDTH'(0));
    reset = 1'b0;

    // Reset mid-stream, asserted between edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(32'h80000300 + 32'(4 * i)), 1'b0, took, pc);
    @(posedge clock);
    #1;
    chk("pre_rst_count", WIDTH'(count), WIDTH'(3));
    enqValid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_count",    WIDTH'(count),    WIDTH'(0));
    chk("async_rst_empty",    WIDTH'(empty),    WIDTH'(1));
    chk("async_rst_deqValid", WIDTH'(deqValid), WIDTH'(0));
    reset = 1'b0;
    mq.delete();

    // Fill and block.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mk(32'h80000000 + 32'(4 * i)), 1'b0, took, pc);
    step(1'b0, 1'b1, mk(32'h80000010), 1'b0, took, pc);
    chk("fill_full",     WIDTH'(full),     WIDTH'(1));
    chk("fill_enqReady", WIDTH'(enqReady), WIDTH'(0));
    step(1'b0, 1'b0, '0, 1'b0, took, pc);
    chk("fill_count_held", WIDTH'(count), WIDTH'(4));

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, took, pc);
      chk("drain_took", WIDTH'(took), WIDTH'(1));
      chk("drain_pc",   WIDTH'(pc),   WIDTH'(32'h80000000 + 32'(4 * i)));
    end
    step(1'b0, 1'b0, '0, 1'b0, took, pc);
    chk("drain_empty", WIDTH'(empty), WIDTH'(1));

    // Wrap-around stream of 10 entries.
    k = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, (i < 10), (i < 10) ? mk(32'h80001000 + 32'(4 * i)) : '0, 1'b1, took, pc);
      if (took) begin
        chk("wrap_pc", WIDTH'(pc), WIDTH'(32'h80001000 + 32'(4 * k)));
        k++;
      end
    end
    chk("wrap_total", WIDTH'(k), WIDTH'(10));

    // Flush priority.
    step(1'b0, 1'b1, mk(32'h80000040), 1'b0, took, pc);
    step(1'b0, 1'b1, mk(32'h80000044), 1'b0, took, pc);
    step(1'b1, 1'b1, mk(32'h80000100), 1'b1, took, pc);
    step(1'b0, 1'b0, '0, 1'b1, took, pc);
    chk("flush_count",    WIDTH'(count),    WIDTH'(0));
    chk("flush_deqValid", WIDTH'(deqValid), WIDTH'(0));
    step(1'b0, 1'b0, '0, 1'b1, took, pc);

    // Bypass (or one-cycle latency without the macro).
    step(1'b0, 1'b1, mk(32'h80000200), 1'b1, took, pc);
    chk("byp_deqValid", WIDTH'(deqValid), WIDTH'(BYP));
    step(1'b0, 1'b0, '0, 1'b1, took, pc);
    chk("byp_next_valid", WIDTH'(deqValid), WIDTH'(!BYP));
    if (!BYP) chk("byp_next_pc", WIDTH'(pc), WIDTH'(32'h80000200));
    step(1'b0, 1'b0, '0, 1'b0, took, pc);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) != 0),
           {$urandom, $urandom, $urandom}, ($urandom_range(0, 2) != 0), took, pc);
    end
    step(1'b0, 1'b0, '0, 1'b0, took, pc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised multi-entry buffer between the fetch and decode stages. It generalises the single fetch/decode pipeline register to DEPTH entries with a valid/ready handshake on both sides.
- Each entry holds {instruction, programCounter, programCounterPlus4}. Entry validity is carried by the handshake, not stored in the payload.
- Absorbs decode stalls without stalling fetch until the queue is full. Flush discards all entries on branch/jump redirect or trap.

Parameters:
- WIDTH, 96, payload bits per entry: instruction[95:64], programCounter[63:32], programCounterPlus4[31:0].
- DEPTH, 4, number of entries; must be a power of two and >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count. Derived; not overridden.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries (redirect/trap).
- enqValid  in  1  fetch presents a payload.
- enqReady  out  1  queue accepts a payload this cycle.
- enqData  in  WIDTH  fetch payload.
- deqValid  out  1  head entry available to decode.
- deqReady  in  1  decode consumes head (= !decode stall).
- deqData  out  WIDTH  head payload.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high.
- Storage: DEPTH x WIDTH register array. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Reset, asserted at any time including mid-operation: head = tail = 0, count = 0. Outputs then read deqValid = 0, empty = 1, full = 0, enqReady = 1.
- Storage contents are not reset. deqData is don't-care while deqValid = 0.
- Enqueue fires when enqValid && enqReady. enqData is written at tail, tail advances, and count increments at the clock edge.
- Dequeue fires when deqValid && deqReady. Head advances and count decrements at the clock edge.
- enqReady = !full. This is combinational from registered state only; there is no dependence on deqReady, so no ready-path loop.
- deqValid = !empty; deqData = storage[head]. Both come from registered state.
- Base latency: a payload enqueued at edge N is visible on deqData/deqValid after edge N and can be consumed at edge N+1.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Full: enqReady = 0, so an enqueue is refused even if a dequeue fires the same cycle. enqValid is ignored and fetch must hold its payload.
- Empty: deqValid = 0 and deqReady is ignored.
- Flush has priority over all other events in the same cycle. At the next edge head = tail = 0 and count = 0.
  - Any enqueue or dequeue presented in the flush cycle is discarded; state does not change because of it.
  - In the flush cycle itself, outputs still reflect pre-flush state.
- Order: strict FIFO. No reordering and no partial-entry writes.
- Assertions, simulation only:
  - count never exceeds DEPTH.
  - No enqueue while full.
  - No dequeue while empty.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when empty && enqValid && !flush, the queue forwards combinationally.
  - deqValid = 1 and deqData = enqData in the same cycle.
  - If deqReady is also 1, the payload passes through. It is not written, pointers do not move, and count stays 0.
  - If deqReady is 0, the payload is written as a normal enqueue.
  - This gives zero-cycle latency when decode is not stalled.
- Not defined: no bypass. deqValid depends only on registered state, and latency is always one cycle.

Test Plan:
- Reset mid-stream: enqueue 3 entries, then pulse reset asynchronously between edges -> count = 0, empty = 1 and deqValid = 0 immediately, before the next edge.
- Fill and block: deqReady = 0, enqueue PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C -> full = 1, enqReady = 0. A fifth enqValid is ignored and count stays 4.
- Drain in order: from the full state, deqReady = 1 for 4 cycles -> deqData.programCounter = 0x80000000, 0x80000004, 0x80000008, 0x8000000C in that order, then empty = 1.
- Wrap-around: stream 10 entries with enqValid and deqReady both held at 1 after the first enqueue -> count stays at 1, all 10 PCs come out in order, and pointers wrap twice with no loss.
- Flush priority: count = 2, then in one cycle flush = 1, enqValid = 1 (PC 0x80000100) and deqReady = 1 -> next cycle count = 0 and deqValid = 0. PC 0x80000100 never appears on deqData.
- Bypass, with FETCH_QUEUE_BYPASS_EN: empty queue, enqValid = 1, enqData.PC = 0x80000200, deqReady = 1 -> deqValid = 1 and deqData.PC = 0x80000200 in the same cycle, count remains 0.
  - Without the macro, the same stimulus gives deqValid = 0 in that cycle and the entry appears on the next cycle.
